// File: rtl/game_pkg.sv
// game_pkg: shared drawing-path constants, requester indices and arbiter state encoding
package game_pkg;
    localparam int COLOUR_W = 9;
    localparam int COORD_W = 15;
    localparam logic [COLOUR_W-1:0] TRANSPARENT = 9'h1FF;
    localparam int SCREEN_PIXELS = 19200;
    localparam int REQ_TOWER = 0;
    localparam int REQ_CAR = 1;
    localparam int REQ_MIDDLE = 2;
    localparam int REQ_LASER = 3;
    typedef enum logic {IDLE, OWN} arb_state_t;
endpackage

// File: rtl/vga_write_arbiter_if.sv
// vga_write_arbiter_if: drawing-engine requests in, shared VGA/map-RAM write port out
interface vga_write_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int COLOUR_W = game_pkg::COLOUR_W,
    parameter int COORD_W = game_pkg::COORD_W
);
    logic [N_REQ-1:0] req;
    logic [N_REQ*COLOUR_W-1:0] req_colour;
    logic [N_REQ*COORD_W-1:0] req_coord;
    logic [N_REQ*COORD_W-1:0] req_mem_add;
    logic [N_REQ-1:0] req_map_wr;
    logic [N_REQ-1:0] grant;
    logic busy;
    logic [COLOUR_W-1:0] colour;
    logic [COORD_W-1:0] coordinates;
    logic VGA_write_enable;
    logic [COORD_W-1:0] map_add;
    logic map_wren;
    modport master (
        output req, req_colour, req_coord, req_mem_add, req_map_wr,
        input grant, busy, colour, coordinates, VGA_write_enable, map_add, map_wren
    );
    modport slave (
        input req, req_colour, req_coord, req_mem_add, req_map_wr,
        output grant, busy, colour, coordinates, VGA_write_enable, map_add, map_wren
    );
endinterface

// File: rtl/vga_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first requester at or after last_owner+1
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    logic [IDX_W-1:0] cand;
    // Scan from farthest to nearest so the nearest candidate overwrites last
    always_comb begin
        idx = '0;
        found = 1'b0;
        cand = '0;
        for (int d = N_REQ; d >= 1; d--) begin
            cand = IDX_W'((int'(last_owner) + d) % N_REQ);
            if (req[cand]) begin
                idx = cand;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: round-robin, burst-capped owner of the VGA pixel port and map RAM write port
module vga_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int COLOUR_W = game_pkg::COLOUR_W,
    parameter int COORD_W = game_pkg::COORD_W,
    parameter int MAX_BURST = game_pkg::SCREEN_PIXELS,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = game_pkg::TRANSPARENT
) (
    input logic clk,
    input logic resetn,
    vga_write_arbiter_if.slave bus
);
    import game_pkg::*;
    localparam int IDX_W = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int CNT_W = 15;
    arb_state_t state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d, last_q, last_d, pick;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
    logic found, accept, rel;
    logic [COLOUR_W-1:0] col_a [N_REQ];
    logic [COORD_W-1:0] crd_a [N_REQ];
    logic [COORD_W-1:0] add_a [N_REQ];
    logic [COLOUR_W-1:0] colour_q;
    logic [COORD_W-1:0] coord_q, map_add_q;
    logic we_q, wren_q;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign col_a[i] = bus.req_colour[i*COLOUR_W +: COLOUR_W];
        assign crd_a[i] = bus.req_coord[i*COORD_W +: COORD_W];
        assign add_a[i] = bus.req_mem_add[i*COORD_W +: COORD_W];
    end

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req(bus.req),
        .last_owner(last_q),
        .idx(pick),
        .found(found)
    );

    assign accept = state_q == OWN && bus.req[owner_q];
    assign cnt_nx = cnt_q + CNT_W'(1);
    // A held request implies an accept, so the cap test only needs req
    assign rel = state_q == OWN && (!bus.req[owner_q] || cnt_nx == CNT_W'(MAX_BURST));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d = last_q;
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = OWN;
                owner_d = pick;
                cnt_d = '0;
            end
        end else begin
            cnt_d = accept ? cnt_nx : cnt_q;
            if (rel) begin
                state_d = IDLE;
                last_d = owner_q;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q <= IDX_W'(N_REQ - 1);
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload registers hold between accepts so the map RAM read address stays valid
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            colour_q <= '0;
            coord_q <= '0;
            map_add_q <= '0;
            we_q <= 1'b0;
            wren_q <= 1'b0;
        end else begin
            we_q <= accept;
            wren_q <= accept && bus.req_map_wr[owner_q] && col_a[owner_q] != TRANSPARENT;
            if (accept) begin
                colour_q <= col_a[owner_q];
                coord_q <= crd_a[owner_q];
                map_add_q <= add_a[owner_q];
            end
        end
    end

    assign bus.grant = state_q == OWN ? N_REQ'(1) << owner_q : '0;
    assign bus.busy = state_q == OWN;
    assign bus.colour = colour_q;
    assign bus.coordinates = coord_q;
    assign bus.VGA_write_enable = we_q;
    assign bus.map_add = map_add_q;
    assign bus.map_wren = wren_q;
endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb_vga_write_arbiter: default and short-burst arbiters against a behavioural reference model
module tb_vga_write_arbiter;
    import game_pkg::*;
    localparam int N = 4;
    localparam int CAP_B = 3;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0] req = '0, mapwr = '0;
    logic [N*9-1:0] col = '0;
    logic [N*15-1:0] crd = '0, madd = '0;
    int n_cmp = 0, n_bad = 0;

    vga_write_arbiter_if #(.N_REQ(N)) bus_a ();
    vga_write_arbiter_if #(.N_REQ(N)) bus_b ();
    assign bus_a.req = req;
    assign bus_a.req_colour = col;
    assign bus_a.req_coord = crd;
    assign bus_a.req_mem_add = madd;
    assign bus_a.req_map_wr = mapwr;
    assign bus_b.req = req;
    assign bus_b.req_colour = col;
    assign bus_b.req_coord = crd;
    assign bus_b.req_mem_add = madd;
    assign bus_b.req_map_wr = mapwr;

    vga_write_arbiter #(.N_REQ(N)) dut_a (.clk(clk), .resetn(resetn), .bus(bus_a));
    vga_write_arbiter #(.N_REQ(N), .MAX_BURST(CAP_B)) dut_b (.clk(clk), .resetn(resetn), .bus(bus_b));

    // Reference: owner = -1 means nobody holds the port
    typedef struct {
        int owner;
        int last;
        int cnt;
        logic [8:0] colour;
        logic [14:0] coord;
        logic we;
        logic [14:0] madd;
        logic wren;
    } model_t;
    model_t m_a, m_b;

    function automatic model_t reset_model();
        model_t m;
        m.owner = -1;
        m.last = N - 1;
        m.cnt = 0;
        m.colour = '0;
        m.coord = '0;
        m.we = 1'b0;
        m.madd = '0;
        m.wren = 1'b0;
        return m;
    endfunction

    function automatic model_t step(model_t m, int cap);
        model_t n = m;
        bit acc = m.owner >= 0 && req[m.owner];
        n.we = acc;
        n.wren = 1'b0;
        if (acc) begin
            n.colour = col[m.owner*9 +: 9];
            n.coord = crd[m.owner*15 +: 15];
            n.madd = madd[m.owner*15 +: 15];
            n.wren = mapwr[m.owner] && n.colour != 9'h1FF;
        end
        if (m.owner < 0) begin
            for (int d = 1; d <= N; d++)
                if (n.owner < 0 && req[(m.last + d) % N]) begin
                    n.owner = (m.last + d) % N;
                    n.cnt = 0;
                end
        end else if (!acc) begin
            n.last = m.owner;
            n.owner = -1;
        end else begin
            n.cnt = m.cnt + 1;
            if (n.cnt == cap) begin
                n.last = m.owner;
                n.owner = -1;
            end
        end
        return n;
    endfunction

    function automatic logic [3:0] exp_grant(model_t m);
        return m.owner < 0 ? 4'b0 : 4'(1 << m.owner);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_a <= reset_model();
            m_b <= reset_model();
        end else begin
            m_a <= step(m_a, SCREEN_PIXELS);
            m_b <= step(m_b, CAP_B);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare();
        chk("a.grant", bus_a.grant, exp_grant(m_a));
        chk("a.busy", bus_a.busy, m_a.owner >= 0);
        chk("a.colour", bus_a.colour, m_a.colour);
        chk("a.coord", bus_a.coordinates, m_a.coord);
        chk("a.we", bus_a.VGA_write_enable, m_a.we);
        chk("a.map_add", bus_a.map_add, m_a.madd);
        chk("a.map_wren", bus_a.map_wren, m_a.wren);
        chk("b.grant", bus_b.grant, exp_grant(m_b));
        chk("b.busy", bus_b.busy, m_b.owner >= 0);
        chk("b.colour", bus_b.colour, m_b.colour);
        chk("b.coord", bus_b.coordinates, m_b.coord);
        chk("b.we", bus_b.VGA_write_enable, m_b.we);
        chk("b.map_add", bus_b.map_add, m_b.madd);
        chk("b.map_wren", bus_b.map_wren, m_b.wren);
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
    endtask

    task automatic rnd_payload();
        for (int i = 0; i < N; i++) begin
            col[i*9 +: 9] = ($urandom_range(3) == 0) ? 9'h1FF : 9'($urandom);
            crd[i*15 +: 15] = 15'($urandom);
            madd[i*15 +: 15] = 15'($urandom);
        end
        mapwr = 4'($urandom);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, n, guard;
        int seq[$];
        logic [3:0] prev;
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        #1 resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant", bus_a.grant, 0);
        chk("rst_we", bus_a.VGA_write_enable, 0);
        compare();
        resetn = 1'b1;
        // Only the middle-state engine, pixel advances after each accept
        req = 4'b0100;
        crd[2*15 +: 15] = 15'd100;
        nw = 0;
        repeat (5) begin
            tick();
            if (bus_a.VGA_write_enable) begin
                chk("p1_coord", bus_a.coordinates, 100 + nw);
                nw++;
                crd[2*15 +: 15] = crd[2*15 +: 15] + 15'd1;
            end
        end
        chk("p1_writes", nw, 4);
        req = '0;
        tick();
        chk("p1_drop", bus_a.grant, 0);
        // Everyone requesting: short-burst arbiter must rotate 0,1,2,3,0
        rst_pulse();
        req = 4'b1111;
        prev = '0;
        repeat (20) begin
            rnd_payload();
            tick();
            if (bus_b.grant != 0 && prev == 0) seq.push_back(int'(bus_b.grant));
            prev = bus_b.grant;
        end
        chk("p2_owners", seq.size() >= 5, 1);
        for (int k = 0; k < 5 && k < seq.size(); k++) chk("p2_rr", seq[k], exp_seq[k]);
        // Transparent pixels reach VGA but never the map
        rst_pulse();
        req = 4'b0001;
        mapwr = 4'b0001;
        col[8:0] = 9'h1FF;
        madd[14:0] = 15'h1234;
        tick();
        tick();
        chk("p3_we", bus_a.VGA_write_enable, 1);
        chk("p3_transp_wren", bus_a.map_wren, 0);
        chk("p3_add_hold", bus_a.map_add, 15'h1234);
        col[8:0] = 9'h0A5;
        madd[14:0] = 15'h0777;
        tick();
        chk("p3_wren", bus_a.map_wren, 1);
        chk("p3_map_add", bus_a.map_add, 15'h0777);
        chk("p3_colour", bus_a.colour, 9'h0A5);
        req = '0;
        tick();
        // Car drops mid-burst, laser follows after exactly one idle cycle
        req = 4'b1010;
        tick();
        chk("p4_car", bus_a.grant, 4'b0010);
        rnd_payload();
        tick();
        req[1] = 1'b0;
        tick();
        chk("p4_idle", bus_a.grant, 0);
        tick();
        chk("p4_laser", bus_a.grant, 4'b1000);
        // Asynchronous reset in the middle of a burst
        req = 4'b1111;
        repeat (6) begin
            rnd_payload();
            tick();
        end
        #2 resetn = 1'b0;
        #1;
        chk("p5_grant", bus_a.grant, 0);
        chk("p5_busy", bus_a.busy, 0);
        chk("p5_we", bus_a.VGA_write_enable, 0);
        chk("p5_wren", bus_a.map_wren, 0);
        chk("p5_colour", bus_a.colour, 0);
        chk("p5_coord", bus_a.coordinates, 0);
        chk("p5_add", bus_a.map_add, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        chk("p5_first", bus_a.grant, 4'b0001);
        // Random traffic with bursty requests
        repeat (1500) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(5) == 0) req[i] = ~req[i];
            rnd_payload();
            tick();
        end
        // Full-frame burst hits the default cap
        rst_pulse();
        req = 4'b0010;
        tick();
        n = 0;
        guard = 0;
        while (bus_a.grant != 0 && guard < 20000) begin
            rnd_payload();
            tick();
            n += int'(bus_a.VGA_write_enable);
            guard++;
        end
        chk("p7_writes", n, SCREEN_PIXELS);
        tick();
        chk("p7_regrant", bus_a.grant, 4'b0010);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_write_arbiter.md
# vga_write_arbiter

Registered arbiter that shares the single VGA pixel-write port and the map-background RAM write/address port among the game's drawing engines: towers, cars, middle-state screens and lasers. Each requester draws in bursts. The arbiter grants one requester at a time with round-robin fairness and a burst cap. Accepted pixels are forwarded to the VGA adapter and the map RAM through one output register stage. The block replaces the unregistered priority mux in the game data path.

## Interface
Parameters:
- N_REQ, 4, number of requesters; index 0 = tower, 1 = car, 2 = middle, 3 = laser
- COLOUR_W, 9, pixel colour width
- COORD_W, 15, packed {x[7:0], y[6:0]} coordinate width; also the map address width
- MAX_BURST, 19200, maximum pixels accepted per grant (one full 160x120 frame)
- TRANSPARENT, 9'h1FF, colour that is never written into the map RAM

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester pixel-valid request
- req_colour  in  N_REQ*COLOUR_W  flattened colours; requester i occupies bits [i*COLOUR_W +: COLOUR_W]
- req_coord  in  N_REQ*COORD_W  flattened VGA coordinates
- req_mem_add  in  N_REQ*COORD_W  flattened map RAM addresses
- req_map_wr  in  N_REQ  requester also writes this pixel into the map RAM
- grant  out  N_REQ  one-hot current owner; all zero when idle
- busy  out  1  an owner is held
- colour  out  COLOUR_W  registered VGA colour
- coordinates  out  COORD_W  registered VGA coordinate
- VGA_write_enable  out  1  registered VGA write strobe
- map_add  out  COORD_W  registered map RAM address; held between writes so the RAM read path stays valid
- map_wren  out  1  registered map RAM write enable

## Operation
- States: IDLE and OWN. Registers: owner index, last_owner index, 15-bit burst counter.
- IDLE:
  - If any req bit is set, select the first requester at or after (last_owner+1) mod N_REQ.
  - Load owner with that index, clear the burst counter, go to OWN.
  - No pixel is accepted in this cycle.
- OWN:
  - grant[owner] = 1. The pixel is accepted in any cycle where req[owner] & grant[owner].
  - Each accepted pixel increments the burst counter.
  - Release when req[owner] = 0, or when an accept brings the counter to MAX_BURST. On release: last_owner <= owner, go to IDLE.
  - The accept in the release cycle (burst-cap case) is completed.
- Forwarding of an accepted pixel:
  - colour <= colour_i; coordinates <= coord_i; VGA_write_enable <= 1.
  - map_add <= mem_add_i.
  - map_wren <= req_map_wr[i] & (colour_i != TRANSPARENT).
- No accept this cycle: VGA_write_enable <= 0 and map_wren <= 0. colour, coordinates and map_add hold their values.
- grant is decoded directly from state and owner. A requester may change its pixel in the cycle after an accept.
- Round-robin rotation: with all req bits held high, owners cycle 0,1,2,3,0,… No requester waits longer than (N_REQ-1) bursts plus N_REQ idle cycles.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, owner = 0, last_owner = N_REQ-1, counter = 0.
  - All outputs 0.
  - With last_owner = N_REQ-1, requester 0 wins the first arbitration.
- Request-to-grant latency: 1 cycle (req seen in IDLE at cycle N, grant high at cycle N+1).
- Accept-to-output latency: 1 cycle. Pixel accepted at edge N appears on the outputs during cycle N+1, for one cycle.
- Throughput: one pixel per cycle while the owner holds req.
- Every owner change costs exactly one IDLE cycle.
- req dropped mid-burst: release in that cycle, no accept. Re-raising req later re-arbitrates.
- Non-owner requests are ignored until the next IDLE cycle.
- A requester index outside N_REQ is never granted.
- Reset asserted mid-burst: all outputs go to 0 immediately. The in-flight pixel is discarded.

## Structure
- Shared package game_pkg holds:
  - COLOUR_W, COORD_W, TRANSPARENT, SCREEN_PIXELS = 19200.
  - Requester index constants REQ_TOWER = 0, REQ_CAR = 1, REQ_MIDDLE = 2, REQ_LASER = 3.
  - The IDLE/OWN state encoding.
- One sub-module, rr_pick: combinational round-robin selector (req, last_owner → index, found).
- Payload muxing and output registers stay in the top module.

## Test plan
- Reset, then only req[2] high for 5 cycles with coord 100..104 → grant = 4'b0100 from cycle 1. VGA_write_enable high during cycles 2..5 with coordinates 100..103. Drop req → grant = 0 the next cycle.
- All four req high continuously, MAX_BURST = 3 → grants 0,1,2,3,0. Each holds for 3 accepts, with one idle cycle between owners.
- Owner 0 writes colour 9'h1FF with req_map_wr = 1 → VGA_write_enable = 1, map_wren = 0. Colour 9'h0A5 → map_wren = 1, map_add = req_mem_add.
- req[3] high throughout while req[1] toggles mid-burst → requester 1 is released on the drop. Requester 3 is granted after exactly one IDLE cycle.
- resetn low during the middle of a burst of 10 pixels → all outputs 0 asynchronously. After release, requester 0 is granted first when all req bits are high.
- req[1] held 19200 cycles with default parameters → exactly 19200 VGA writes, then one IDLE cycle, then re-grant to requester 1 if it is still the only requester.
